// File: rtl/uart_dbg_display.sv
// UART debug capture: RX/TX byte histories, saturating event counters and a
// debounced page selector that picks the 32-bit word shown on the hex display.
module uart_dbg_display #(
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iRX_VALID,
    input  logic [7:0]  iRX_DATA,
    input  logic        iTX_VALID,
    input  logic [7:0]  iTX_DATA,
    input  logic        iERR,
    input  logic        iCLR,
    input  logic        iKEY_N,
    output logic [31:0] oDIG,
    output logic [1:0]  oPAGE
);

    localparam int unsigned DebW = $clog2(DEB_CYCLES);
    localparam logic [DebW-1:0] DebMax = DebW'(DEB_CYCLES - 1);

    logic [31:0]     rx_h_q, rx_h_d, tx_h_q, tx_h_d;
    logic [15:0]     rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d, err_cnt_q, err_cnt_d;
    logic            key_m_q, key_s_q;
    logic            key_db_q, key_db_d, key_db_prev_q;
    logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]      page_q, page_d, page_out_q;
    logic [31:0]     dig_q, dig_d;

    // Capture path: clear has priority and drops any coincident strobe.
    always_comb begin
        rx_h_d    = rx_h_q;
        tx_h_d    = tx_h_q;
        rx_cnt_d  = rx_cnt_q;
        tx_cnt_d  = tx_cnt_q;
        err_cnt_d = err_cnt_q;
        if (iCLR) begin
            rx_h_d    = '0;
            tx_h_d    = '0;
            rx_cnt_d  = '0;
            tx_cnt_d  = '0;
            err_cnt_d = '0;
        end else begin
            if (iRX_VALID) begin
                rx_h_d = {rx_h_q[23:0], iRX_DATA};
                if (rx_cnt_q != 16'hFFFF) rx_cnt_d = rx_cnt_q + 16'd1;
            end
            if (iTX_VALID) begin
                tx_h_d = {tx_h_q[23:0], iTX_DATA};
                if (tx_cnt_q != 16'hFFFF) tx_cnt_d = tx_cnt_q + 16'd1;
            end
            if (iERR && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Debounce: the new level must persist DEB_CYCLES cycles at the synchronizer.
    always_comb begin
        key_db_d  = key_db_q;
        deb_cnt_d = '0;
        if (key_s_q != key_db_q) begin
            if (deb_cnt_q == DebMax) begin
                key_db_d = key_s_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        page_d = page_q;
        if (key_db_prev_q && !key_db_q) page_d = page_q + 2'd1;
    end

    always_comb begin
        dig_d = '0;
        unique case (page_q)
            2'd0: dig_d = rx_h_q;
            2'd1: dig_d = tx_h_q;
            2'd2: dig_d = {rx_cnt_q, tx_cnt_q};
            2'd3: dig_d = {8'h00, rx_h_q[7:0], err_cnt_q};
            default: dig_d = '0;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rx_h_q        <= '0;
            tx_h_q        <= '0;
            rx_cnt_q      <= '0;
            tx_cnt_q      <= '0;
            err_cnt_q     <= '0;
            key_m_q       <= 1'b1;
            key_s_q       <= 1'b1;
            key_db_q      <= 1'b1;
            key_db_prev_q <= 1'b1;
            deb_cnt_q     <= '0;
            page_q        <= '0;
            page_out_q    <= '0;
            dig_q         <= '0;
        end else begin
            rx_h_q        <= rx_h_d;
            tx_h_q        <= tx_h_d;
            rx_cnt_q      <= rx_cnt_d;
            tx_cnt_q      <= tx_cnt_d;
            err_cnt_q     <= err_cnt_d;
            key_m_q       <= iKEY_N;
            key_s_q       <= key_m_q;
            key_db_q      <= key_db_d;
            key_db_prev_q <= key_db_q;
            deb_cnt_q     <= deb_cnt_d;
            page_q        <= page_d;
            page_out_q    <= page_q;
            dig_q         <= dig_d;
        end
    end

    assign oDIG  = dig_q;
    assign oPAGE = page_out_q;

endmodule

// File: tb/tb_uart_dbg_display.sv
// Self-checking bench for uart_dbg_display: random strobes against a byte-list
// and saturating-count model, plus directed key, clear and reset scenarios.
module tb_uart_dbg_display;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iRX_VALID = 1'b0, iTX_VALID = 1'b0, iERR = 1'b0, iCLR = 1'b0;
    logic [7:0]  iRX_DATA = '0, iTX_DATA = '0;
    logic        iKEY_N = 1'b1;
    logic [31:0] oDIG;
    logic [1:0]  oPAGE;

    int tests = 0;
    int fails = 0;

    // Model: last four bytes (index 0 newest), plain integer counts, page index.
    logic [7:0] m_rx[4];
    logic [7:0] m_tx[4];
    int         m_rxc, m_txc, m_errc, m_page;

    uart_dbg_display #(.DEB_CYCLES(4)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iRX_VALID(iRX_VALID), .iRX_DATA(iRX_DATA),
        .iTX_VALID(iTX_VALID), .iTX_DATA(iTX_DATA),
        .iERR(iERR), .iCLR(iCLR), .iKEY_N(iKEY_N),
        .oDIG(oDIG), .oPAGE(oPAGE)
    );

    always #5 iCLK = ~iCLK;

    function automatic int sat_inc(int v);
        return (v < 65535) ? v + 1 : 65535;
    endfunction

    function automatic logic [31:0] disp();
        logic [15:0] rc, tc, ec;
        rc = 16'(m_rxc);
        tc = 16'(m_txc);
        ec = 16'(m_errc);
        case (m_page)
            0: return {m_rx[3], m_rx[2], m_rx[1], m_rx[0]};
            1: return {m_tx[3], m_tx[2], m_tx[1], m_tx[0]};
            2: return {rc, tc};
            default: return {8'h00, m_rx[0], ec};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_rx[i] = 8'h00;
            m_tx[i] = 8'h00;
        end
        m_rxc = 0; m_txc = 0; m_errc = 0; m_page = 0;
    endtask

    // Drive one cycle of inputs (starting at a negedge), update the model, and
    // return at the following negedge.
    task automatic cycle(input bit rx, input logic [7:0] rd, input bit tx,
                         input logic [7:0] td, input bit err, input bit clr);
        iRX_VALID = rx; iRX_DATA = rd; iTX_VALID = tx; iTX_DATA = td;
        iERR = err; iCLR = clr;
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                m_rx[i] = 8'h00;
                m_tx[i] = 8'h00;
            end
            m_rxc = 0; m_txc = 0; m_errc = 0;
        end else begin
            if (rx) begin
                for (int i = 3; i > 0; i--) m_rx[i] = m_rx[i-1];
                m_rx[0] = rd;
                m_rxc = sat_inc(m_rxc);
            end
            if (tx) begin
                for (int i = 3; i > 0; i--) m_tx[i] = m_tx[i-1];
                m_tx[0] = td;
                m_txc = sat_inc(m_txc);
            end
            if (err) m_errc = sat_inc(m_errc);
        end
        @(negedge iCLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic press();
        iKEY_N = 1'b0;
        idle(10);
        iKEY_N = 1'b1;
        idle(10);
        m_page = (m_page + 1) % 4;
    endtask

    task automatic test_reset();
        model_reset();
        iRST_N = 1'b0;
        repeat (3) @(negedge iCLK);
        tests++;
        if (oDIG !== 32'h0) begin
            fails++; $display("FAIL reset_dig got %h exp %h", oDIG, 32'h0);
        end
        tests++;
        if (oPAGE !== 2'd0) begin
            fails++; $display("FAIL reset_page got %0d exp 0", oPAGE);
        end
        iRST_N = 1'b1;
        @(negedge iCLK);
    endtask

    task automatic test_rx_history();
        logic [7:0] bytes[5];
        bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56;
        bytes[3] = 8'h78; bytes[4] = 8'h9A;
        for (int i = 0; i < 5; i++) cycle(1'b1, bytes[i], 1'b0, 8'h00, 1'b0, 1'b0);
        idle(2);
        tests++;
        if (oDIG !== 32'h3456789A || oDIG !== disp()) begin
            fails++; $display("FAIL rx_history got %h exp %h", oDIG, 32'h3456789A);
        end
    endtask

    task automatic test_pages();
        for (int p = 0; p < 4; p++) begin
            press();
            tests++;
            if (oPAGE !== 2'(m_page) || oDIG !== disp()) begin
                fails++;
                $display("FAIL page_step got page %0d dig %h exp page %0d dig %h",
                         oPAGE, oDIG, m_page, disp());
            end
            if (m_page == 2) begin
                tests++;
                if (oDIG !== 32'h0005_0000) begin
                    fails++; $display("FAIL page2_counts got %h exp %h", oDIG, 32'h0005_0000);
                end
            end
            if (m_page == 3) begin
                tests++;
                if (oDIG !== 32'h009A_0000) begin
                    fails++; $display("FAIL page3_view got %h exp %h", oDIG, 32'h009A_0000);
                end
            end
        end
    endtask

    task automatic test_bounce();
        for (int r = 0; r < 5; r++) begin
            iKEY_N = 1'b0;
            idle(3);
            iKEY_N = 1'b1;
            idle(10);
        end
        tests++;
        if (oPAGE !== 2'(m_page)) begin
            fails++; $display("FAIL bounce_page got %0d exp %0d", oPAGE, m_page);
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] exp_prev;
        exp_prev = disp();
        for (int i = 0; i < n; i++) begin
            tests++;
            if (oDIG !== exp_prev) begin
                fails++;
                $display("FAIL random_dig page %0d cycle %0d got %h exp %h",
                         m_page, i, oDIG, exp_prev);
            end
            exp_prev = disp();
            cycle(1'($urandom_range(1)), 8'($urandom_range(255)),
                  1'($urandom_range(1)), 8'($urandom_range(255)),
                  1'($urandom_range(1)), ($urandom_range(31) == 0));
        end
        idle(2);
    endtask

    task automatic test_saturation();
        while (m_page != 3) press();
        for (int i = 0; i < 70000; i++)
            cycle(1'b1, 8'($urandom_range(255)), 1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);
        tests++;
        if (oDIG[15:0] !== 16'hFFFF || oDIG !== disp()) begin
            fails++; $display("FAIL sat_err got %h exp %h", oDIG, disp());
        end
        press(); press(); press();
        tests++;
        if (oDIG[31:16] !== 16'hFFFF || oDIG !== disp()) begin
            fails++; $display("FAIL sat_rx got %h exp %h", oDIG, disp());
        end
    endtask

    task automatic test_clear();
        int pg;
        pg = m_page;
        cycle(1'b1, 8'hAB, 1'b1, 8'hCD, 1'b1, 1'b1);
        idle(1);
        tests++;
        if (oDIG !== 32'h0 || oPAGE !== 2'(pg)) begin
            fails++; $display("FAIL clear got dig %h page %0d exp dig 0 page %0d", oDIG, oPAGE, pg);
        end
        for (int p = 0; p < 4; p++) begin
            press();
            tests++;
            if (oDIG !== 32'h0) begin
                fails++; $display("FAIL clear_page%0d got %h exp 0", m_page, oDIG);
            end
        end
    endtask

    task automatic test_mid_reset();
        iKEY_N = 1'b0;
        idle(2);
        #2 iRST_N = 1'b0;
        #1;
        tests++;
        if (oPAGE !== 2'd0 || oDIG !== 32'h0) begin
            fails++; $display("FAIL midrst_async got page %0d dig %h exp 0", oPAGE, oDIG);
        end
        @(negedge iCLK);
        iRST_N = 1'b1;
        model_reset();
        idle(6);
        tests++;
        if (oPAGE !== 2'd0) begin
            fails++; $display("FAIL midrst_early got %0d exp 0", oPAGE);
        end
        idle(6);
        tests++;
        if (oPAGE !== 2'd1) begin
            fails++; $display("FAIL midrst_press got %0d exp 1", oPAGE);
        end
        iKEY_N = 1'b1;
        idle(10);
        m_page = 1;
    endtask

    initial begin
        @(negedge iCLK);
        test_reset();
        test_rx_history();
        test_pages();
        test_bounce();
        test_random(300);
        press();
        test_random(300);
        test_saturation();
        test_clear();
        test_mid_reset();
        test_random(300);
        press(); press();
        test_random(300);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
